spi_xfer_sequencer: RTL and testbench
=====================================

# spi_xfer_sequencer

Byte-stream front end that sits directly upstream of `spi_module`. It buffers outgoing bytes in a TX FIFO, presents each byte on `spi_module.i_data`, pulses `trans_en`, waits for `interupt_request`, and stores the received `o_data` byte in an RX FIFO. It also owns the 32-bit `data_config` word (C1, C2, status, baud) and applies updates only between transfers, so the SPI core never sees a configuration change mid-frame.

## Interface
- `DATA_W`, 8: SPI frame width in bits.
- `DEPTH`, 8: entries per FIFO (power of two, ≥2).
- `CFG_RESET`, 32'h0000_8011: `data_config` value after reset.
- `TIMEOUT_CYC`, 4096: maximum cycles in WAIT before a transfer is abandoned.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_valid` / `tx_ready` / `tx_data`  in / out / in  1 / 1 / DATA_W  TX push handshake.
- `rx_valid` / `rx_ready` / `rx_data`  out / in / out  1 / 1 / DATA_W  RX pop handshake.
- `cfg_load`  in  1  request to replace the config word.
- `cfg_in`  in  32  new config word, sampled when `cfg_load`=1.
- `spi_data_config`  out  32  to `spi_module.data_config`.
- `spi_i_data`  out  DATA_W  to `spi_module.i_data`.
- `spi_trans_en`  out  1  to `spi_module.trans_en`, one-cycle pulse.
- `spi_irq`  in  1  from `spi_module.interupt_request`.
- `spi_o_data`  in  DATA_W  from `spi_module.o_data`.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky; cleared only by `rst`.
- `tx_count` / `rx_count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: FIFOs empty, FSM in IDLE, `spi_trans_en`=0, `spi_i_data`=0, `spi_data_config`=CFG_RESET, `busy`=0, `timeout_err`=0, `rx_valid`=0, `tx_ready`=1, counts 0, pending-config flag cleared.
- TX push occurs when `tx_valid && tx_ready`; `tx_ready` = (`tx_count` < DEPTH). RX pop occurs when `rx_valid && rx_ready`; `rx_valid` = (`rx_count` ≠ 0). `rx_data` is the FIFO head (show-ahead).
- Config: `cfg_load` in IDLE writes `spi_data_config` on the next edge. `cfg_load` in any other state stores `cfg_in` in a pending register; the last request wins. The pending word is applied on the first IDLE cycle, and that cycle does not start a transfer.
- FSM:
  - IDLE: no pending config, `tx_count`≠0, and `rx_count`<DEPTH -> LOAD.
  - LOAD: pop TX head into `spi_i_data` -> START.
  - START: `spi_trans_en`=1 -> WAIT.
  - WAIT: on a rising edge of `spi_irq` (registered previous value), go to CAPTURE. If the counter reaches TIMEOUT_CYC first, set `timeout_err` and return to IDLE without an RX write; the popped TX byte is dropped.
  - CAPTURE: write `spi_o_data` into the RX FIFO -> IDLE.
- Exactly one transfer is in flight at a time. The RX-space check in IDLE guarantees the RX FIFO can never overflow.
- Edges of `spi_irq` seen outside WAIT are ignored.
- Simultaneous push and pop on the same FIFO is legal, including when the FIFO is full (TX pop by LOAD with `tx_count`=DEPTH) or empty. Count is unchanged when both occur in the same cycle.

## Timing
- `tx_data` pushed into an empty TX FIFO at edge N:
  - edge N+1: IDLE→LOAD.
  - edge N+2: `spi_i_data` valid, `spi_trans_en` high during cycle N+2→N+3.
- `spi_irq` rising, sampled at edge M: CAPTURE during cycle M→M+1; `rx_valid` high after edge M+2.
- Minimum gap between back-to-back `trans_en` pulses = SPI frame time + 4 cycles.
- Reset mid-WAIT returns to IDLE on the next edge. The SPI core's own reset is handled externally.

## Structure
- Package `spi_seq_pkg`:
  - state enum: IDLE, LOAD, START, WAIT, CAPTURE.
  - config byte offsets: C1 [31:24], C2 [23:16], STATUS [15:8], BAUD [7:0].
  - default CFG_RESET.
- Sub-module `spi_sync_fifo` (DATA_W, DEPTH; push/pop/full/empty/count), instantiated twice (TX and RX).

## Test plan
- Reset, then push 0xA5 -> `spi_i_data`=0xA5, one `trans_en` pulse 2 cycles after the push; loopback MISO returns 0x5A -> `rx_data`=0x5A, `rx_count`=1.
- Push 8 bytes 0x01..0x08 with `rx_ready`=0 -> exactly 8 transfers in order, then the FSM stalls in IDLE with `rx_count`=8. One pop -> a 9th queued byte transfers.
- `cfg_load` with 32'h5610_8031 during WAIT -> `spi_data_config` unchanged until the transfer completes, then updated in IDLE before the next `trans_en`.
- `spi_irq` held low -> after 4096 WAIT cycles `timeout_err`=1, no RX write, the next queued byte still transfers.
- Assert `rst` mid-WAIT with 3 bytes queued -> next cycle all outputs are at reset values and the counts are 0.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transfer sequencer: FSM states,
// config-word byte positions and the default config value.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4
  } seq_state_e;

  // Byte lanes of the spi_module data_config word.
  localparam int CFG_C1_LSB     = 24;
  localparam int CFG_C2_LSB     = 16;
  localparam int CFG_STATUS_LSB = 8;
  localparam int CFG_BAUD_LSB   = 0;

  localparam logic [31:0] CFG_RESET_DEFAULT = 32'h0000_8011;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; push and pop may
// coincide in any fill state, including full and empty.
module spi_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              wr_en_s;
  logic              rd_en_s;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign count   = count_r;
  assign head    = mem_r[rd_ptr_r];
  assign rd_en_s = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_s = push & (~full | rd_en_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Byte-stream front end for spi_module: TX/RX FIFOs, one-at-a-time transfer
// sequencing and config-word updates deferred to frame boundaries.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] CFG_RESET   = CFG_RESET_DEFAULT,
  parameter int          TIMEOUT_CYC = 4096,
  localparam int         CW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  input  logic              cfg_load,
  input  logic [31:0]       cfg_in,
  output logic [31:0]       spi_data_config,
  output logic [DATA_W-1:0] spi_i_data,
  output logic              spi_trans_en,
  input  logic              spi_irq,
  input  logic [DATA_W-1:0] spi_o_data,
  output logic              busy,
  output logic              timeout_err,
  output logic [CW-1:0]     tx_count,
  output logic [CW-1:0]     rx_count
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  seq_state_e        state_r;
  logic              irq_prev_r;
  logic [TW-1:0]     wait_cnt_r;
  logic              cfg_pend_r;
  logic [31:0]       cfg_pend_val_r;
  logic              rx_push_r;
  logic [DATA_W-1:0] rx_wdata_r;

  logic              tx_push_s;
  logic              tx_pop_s;
  logic              rx_pop_s;
  logic              tx_full_s;
  logic              tx_empty_s;
  logic              rx_full_s;
  logic              rx_empty_s;
  logic              rx_room_s;
  logic [DATA_W-1:0] tx_head_s;

  assign tx_ready  = ~tx_full_s;
  assign rx_valid  = ~rx_empty_s;
  assign tx_push_s = tx_valid & tx_ready;
  assign rx_pop_s  = rx_valid & rx_ready;
  assign tx_pop_s  = (state_r == LOAD);
  assign busy      = (state_r != IDLE);

  spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push_s),
    .push_data (tx_data),
    .pop       (tx_pop_s),
    .head      (tx_head_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s),
    .count     (tx_count)
  );

  spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_r),
    .push_data (rx_wdata_r),
    .pop       (rx_pop_s),
    .head      (rx_data),
    .full      (rx_full_s),
    .empty     (rx_empty_s),
    .count     (rx_count)
  );

  // RX space check counts a capture still on its way into the RX FIFO.
  always_comb begin
    rx_room_s = 1'b0;
    if (rx_push_r) begin
      rx_room_s = (rx_count < CW'(DEPTH - 1));
    end else begin
      rx_room_s = ~rx_full_s;
    end
  end

  // Transfer FSM, config ownership and timeout supervision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      irq_prev_r      <= 1'b0;
      wait_cnt_r      <= {TW{1'b0}};
      cfg_pend_r      <= 1'b0;
      cfg_pend_val_r  <= 32'h0000_0000;
      rx_push_r       <= 1'b0;
      rx_wdata_r      <= {DATA_W{1'b0}};
      spi_data_config <= CFG_RESET;
      spi_i_data      <= {DATA_W{1'b0}};
      spi_trans_en    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      irq_prev_r   <= spi_irq;
      spi_trans_en <= 1'b0;
      rx_push_r    <= 1'b0;
      if (cfg_load && (state_r != IDLE)) begin
        cfg_pend_r     <= 1'b1;
        cfg_pend_val_r <= cfg_in;
      end
      case (state_r)
        IDLE: begin
          if (cfg_load) begin
            spi_data_config <= cfg_in;
            cfg_pend_r      <= 1'b0;
          end else if (cfg_pend_r) begin
            spi_data_config <= cfg_pend_val_r;
            cfg_pend_r      <= 1'b0;
          end
          // The cycle that applies a deferred config never starts a frame.
          if (!cfg_pend_r && !tx_empty_s && rx_room_s) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          spi_i_data   <= tx_head_s;
          spi_trans_en <= 1'b1;
          state_r      <= START;
        end
        START: begin
          wait_cnt_r <= {TW{1'b0}};
          state_r    <= WAIT;
        end
        WAIT: begin
          if (spi_irq && !irq_prev_r) begin
            state_r <= CAPTURE;
          end else if (wait_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            state_r     <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end
        CAPTURE: begin
          rx_push_r  <= 1'b1;
          rx_wdata_r <= spi_o_data;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer: directed scenarios plus a
// randomized phase, checked against queue-based TX/RX/config models.
module tb_spi_xfer_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int TOUT   = 4096;
  localparam logic [31:0] CFG_RST = 32'h0000_8011;

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              cfg_load;
  logic [31:0]       cfg_in;
  logic [31:0]       spi_data_config;
  logic [DATA_W-1:0] spi_i_data;
  logic              spi_trans_en;
  logic              spi_irq;
  logic [DATA_W-1:0] spi_o_data;
  logic              busy;
  logic              timeout_err;
  logic [CW-1:0]     tx_count;
  logic [CW-1:0]     rx_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [31:0] exp_cfg = CFG_RST;
  int          frame_lo = 2;
  int          frame_hi = 10;
  bit          drop_next = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CFG_RESET(CFG_RST), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .cfg_load(cfg_load), .cfg_in(cfg_in),
    .spi_data_config(spi_data_config), .spi_i_data(spi_i_data),
    .spi_trans_en(spi_trans_en), .spi_irq(spi_irq), .spi_o_data(spi_o_data),
    .busy(busy), .timeout_err(timeout_err),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    while (tx_ready !== 1'b1 && k < 200) begin tick(); k++; end
    check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_valid = 1'b1;
    tx_data  = b;
    exp_tx_q.push_back(b);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int k = 0;
    logic [31:0] e;
    while (rx_valid !== 1'b1 && k < 300) begin tick(); k++; end
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    if (exp_rx_q.size() != 0) e = {24'd0, exp_rx_q.pop_front()};
    else e = 32'hFFFF_FFFF;
    check(tag, {24'd0, rx_data}, e);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic wait_trans_en(input string tag);
    int k = 0;
    while (spi_trans_en !== 1'b1 && k < 300) begin tick(); k++; end
    check(tag, {31'd0, spi_trans_en}, 32'd1);
  endtask

  task automatic wait_rx_count(input string tag, input int n);
    int k = 0;
    while (rx_count !== CW'(n) && k < 2000) begin tick(); k++; end
    check(tag, {28'd0, rx_count}, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {31'd0, busy},         32'd0);
    check({tag, "_txrdy"},  {31'd0, tx_ready},     32'd1);
    check({tag, "_rxvld"},  {31'd0, rx_valid},     32'd0);
    check({tag, "_txcnt"},  {28'd0, tx_count},     32'd0);
    check({tag, "_rxcnt"},  {28'd0, rx_count},     32'd0);
    check({tag, "_cfg"},    spi_data_config,       CFG_RST);
    check({tag, "_idata"},  {24'd0, spi_i_data},   32'd0);
    check({tag, "_ten"},    {31'd0, spi_trans_en}, 32'd0);
    check({tag, "_tout"},   {31'd0, timeout_err},  32'd0);
  endtask

  // SPI core stand-in: answers each trans_en with ~i_data after a frame delay.
  initial begin : spi_slave
    logic [7:0]  d;
    logic [31:0] e;
    int          n;
    bit          drop;
    spi_irq    = 1'b0;
    spi_o_data = 8'h00;
    forever begin
      tick();
      if (spi_trans_en === 1'b1) begin
        d = spi_i_data;
        if (exp_tx_q.size() != 0) e = {24'd0, exp_tx_q.pop_front()};
        else e = 32'hFFFF_FFFF;
        check("tx_order", {24'd0, d}, e);
        check("cfg_at_xfer", spi_data_config, exp_cfg);
        drop      = drop_next;
        drop_next = 1'b0;
        if (!drop) begin
          n = $urandom_range(frame_hi, frame_lo);
          repeat (n) @(posedge clk);
          #1;
          spi_o_data = ~d;
          spi_irq    = 1'b1;
          exp_rx_q.push_back(~d);
          tick();
          spi_irq = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int j;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    cfg_load = 1'b0; cfg_in = 32'h0000_0000;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single byte: timing of LOAD/trans_en and loopback capture.
    frame_lo = 4; frame_hi = 4;
    push_byte(8'hA5);
    check("t1_idle_at_push", {31'd0, busy}, 32'd0);
    tick();
    check("t1_busy_load", {31'd0, busy}, 32'd1);
    check("t1_ten_early", {31'd0, spi_trans_en}, 32'd0);
    tick();
    check("t1_ten", {31'd0, spi_trans_en}, 32'd1);
    check("t1_idata", {24'd0, spi_i_data}, 32'h0000_00A5);
    tick();
    check("t1_ten_pulse", {31'd0, spi_trans_en}, 32'd0);
    wait_rx_count("t1_rxcnt", 1);
    check("t1_rxdata", {24'd0, rx_data}, 32'h0000_005A);
    pop_check("t1_pop");

    // RX full stall with nine queued bytes.
    frame_lo = 2; frame_hi = 10;
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    wait_rx_count("t2_fill", DEPTH);
    repeat (40) tick();
    check("t2_rxcnt_stall", {28'd0, rx_count}, DEPTH);
    check("t2_txcnt_stall", {28'd0, tx_count}, 32'd1);
    check("t2_busy_stall",  {31'd0, busy},     32'd0);
    pop_check("t2_first");
    wait_rx_count("t2_refill", DEPTH);
    check("t2_txcnt_empty", {28'd0, tx_count}, 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_check("t2_drain");
    check("t2_rx_empty", {31'd0, rx_valid}, 32'd0);

    // Config: direct write in IDLE, deferred write during WAIT.
    frame_lo = 20; frame_hi = 20;
    cfg_load = 1'b1; cfg_in = 32'h1234_8022;
    tick();
    cfg_load = 1'b0;
    check("cfg_idle_direct", spi_data_config, 32'h1234_8022);
    exp_cfg = 32'h1234_8022;
    push_byte(8'h11);
    push_byte(8'h22);
    wait_trans_en("cfg_first_xfer");
    repeat (2) tick();
    cfg_load = 1'b1; cfg_in = 32'h5610_8031;
    tick();
    cfg_load = 1'b0;
    check("cfg_held_wait", spi_data_config, 32'h1234_8022);
    exp_cfg = 32'h5610_8031;
    repeat (5) tick();
    check("cfg_held_wait2", spi_data_config, 32'h1234_8022);
    wait_trans_en("cfg_second_xfer");
    check("cfg_applied", spi_data_config, 32'h5610_8031);
    pop_check("cfg_rx0");
    pop_check("cfg_rx1");

    // Timeout: first transfer never answered, second must still run.
    frame_lo = 2; frame_hi = 6;
    drop_next = 1'b1;
    push_byte(8'h6B);
    push_byte(8'hC4);
    wait_trans_en("to_xfer");
    check("to_err_before", {31'd0, timeout_err}, 32'd0);
    j = 0;
    while (busy !== 1'b0 && j < 5000) begin tick(); j++; end
    check("to_wait_len", j, TOUT + 1);
    check("to_err_set", {31'd0, timeout_err}, 32'd1);
    check("to_no_rx", {28'd0, rx_count}, 32'd0);
    pop_check("to_next");
    check("to_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Randomized traffic.
    frame_lo = 1; frame_hi = 8;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(2, 0) != 0 && tx_ready === 1'b1) push_byte(8'($urandom));
      else tick();
      if (rx_valid === 1'b1 && $urandom_range(1, 0) == 1) pop_check("rand_rx");
    end
    j = 0;
    while ((tx_count !== 0 || busy !== 1'b0) && j < 3000) begin tick(); j++; end
    repeat (4) tick();
    check("rand_rxcnt", {28'd0, rx_count}, exp_rx_q.size());
    while (exp_rx_q.size() != 0) pop_check("rand_drain");

    // Reset in the middle of WAIT with three bytes queued.
    frame_lo = 30; frame_hi = 30;
    push_byte(8'h71);
    wait_trans_en("rst_xfer");
    push_byte(8'h72);
    push_byte(8'h73);
    push_byte(8'h74);
    check("rst_pre_txcnt", {28'd0, tx_count}, 32'd3);
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    cfg_load = 1'b1; cfg_in = 32'hDEAD_BEEF;
    tick();
    cfg_load = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    exp_cfg = CFG_RST;
    exp_tx_q.delete();
    repeat (45) tick();
    exp_rx_q.delete();
    check("rst_irq_ignored", {28'd0, rx_count}, 32'd0);
    check("rst_idle", {31'd0, busy}, 32'd0);
    check("rst_pend_cleared", spi_data_config, CFG_RST);
    frame_lo = 3; frame_hi = 3;
    push_byte(8'h3C);
    pop_check("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
